// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and sizing for the memory bus arbiter.
// This package is the single configuration point: NREQ and the bus widths live here.
package mem_bus_pkg;

  localparam int unsigned NREQ   = 2;
  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_w;
    logic [MASK_W-1:0] mask_w;
  } bus_req_t;

  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side bus of the arbiter: per-master request lanes and the shared response.
// BUS_ARB_LOCK_EN adds the req_lock lane.
interface mem_bus_arbiter_if;
  import mem_bus_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data_w;
  logic [NREQ*MASK_W-1:0] req_mask_w;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
`ifdef BUS_ARB_LOCK_EN
  logic [NREQ-1:0]        req_lock;

  modport master (
    output req_valid, req_addr, req_data_w, req_mask_w, req_lock,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_addr, req_data_w, req_mask_w, req_lock,
    output req_ready, rsp_valid, rsp_data
  );
`else
  modport master (
    output req_valid, req_addr, req_data_w, req_mask_w,
    input  req_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  req_valid, req_addr, req_data_w, req_mask_w,
    output req_ready, rsp_valid, rsp_data
  );
`endif

endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester searching upward from last+1.
// The valid vector is duplicated so the wrap-around search becomes a plain lowest-set-bit scan.
module rr_picker #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IdW-1:0]  last_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IdW-1:0]  id_o
);

  logic [2*NREQ-1:0] dbl_masked;

  // Lower copy loses positions up to and including last; upper copy covers the wrap.
  always_comb begin
    dbl_masked = {valid_i, valid_i};
    for (int j = 0; j < int'(NREQ); j++) begin
      if (j <= int'(last_i)) dbl_masked[j] = 1'b0;
    end
  end

  // Lowest set bit of the masked vector, folded back into the requester range.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    id_o    = '0;
    grant_o = '0;
    for (int j = 2 * int'(NREQ) - 1; j >= 0; j--) begin
      if (dbl_masked[j]) idx = (j >= int'(NREQ)) ? (j - NREQ) : j;
    end
    id_o = IdW'(idx);
    if (|valid_i) grant_o[id_o] = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NREQ masters.
// One transaction per cycle, fixed two-cycle response latency, responses in acceptance order.
// Define BUS_ARB_LOCK_EN to add req_lock for read-modify-write atomics.
module mem_bus_arbiter
  import mem_bus_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_w_o,
  output logic [MASK_W-1:0] mem_mask_w_o,
  input  logic [DATA_W-1:0] mem_data_r_i
);

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] grant;
  req_id_t         gid;
  req_id_t         last_q;
  logic            hs;
  bus_req_t        win;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_w_q;
  logic [MASK_W-1:0] mem_mask_w_q;
  logic              s1_valid_q, s2_valid_q;
  req_id_t           s1_id_q, s2_id_q;

`ifdef BUS_ARB_LOCK_EN
  logic    lock_q;
  req_id_t lock_id_q;
`endif

  // Candidates for the picker; a held lock hides every requester but the owner.
  always_comb begin
    cand = bus.req_valid;
`ifdef BUS_ARB_LOCK_EN
    if (lock_q) cand = bus.req_valid & (NREQ'(1) << lock_id_q);
`endif
  end

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .valid_i (cand),
    .last_i  (last_q),
    .grant_o (grant),
    .id_o    (gid)
  );

  assign bus.req_ready = grant;
  // grant is a subset of req_valid, so any grant bit is a handshake.
  assign hs = |grant;

  // Request fields of the current winner.
  always_comb begin
    win        = '0;
    win.addr   = bus.req_addr[int'(gid)*ADDR_W +: ADDR_W];
    win.data_w = bus.req_data_w[int'(gid)*DATA_W +: DATA_W];
    win.mask_w = bus.req_mask_w[int'(gid)*MASK_W +: MASK_W];
  end

  // Issue registers, round-robin pointer and the two-stage response pipeline.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q       <= req_id_t'(NREQ - 1);
      mem_addr_q   <= '0;
      mem_data_w_q <= '0;
      mem_mask_w_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_id_q      <= '0;
    end else begin
      if (hs) begin
        last_q       <= gid;
        mem_addr_q   <= win.addr;
        mem_data_w_q <= win.data_w;
        mem_mask_w_q <= win.mask_w;
      end else begin
        // Dropping the mask keeps every write exactly one cycle wide.
        mem_mask_w_q <= '0;
      end
      s1_valid_q <= hs;
      s1_id_q    <= gid;
      s2_valid_q <= s1_valid_q;
      s2_id_q    <= s1_id_q;
    end
  end

`ifdef BUS_ARB_LOCK_EN
  // Owner's handshake sets or releases the lock; only the owner can handshake while locked.
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (hs) begin
      lock_q    <= bus.req_lock[gid];
      lock_id_q <= gid;
    end
  end
`endif

  // Response pulse to the requester whose transaction is in stage 2.
  always_comb begin
    bus.rsp_valid = '0;
    if (s2_valid_q) bus.rsp_valid[s2_id_q] = 1'b1;
  end

  assign bus.rsp_data  = mem_data_r_i;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_w_o  = mem_data_w_q;
  assign mem_mask_w_o  = mem_mask_w_q;

endmodule
